apb_slave_regs: RTL and testbench

- APB3 completer (slave) for the team's APB master; one instance per decoded PSELx.
- Holds two operand registers A/B, a read-only RESULT = A+B, and a STATUS/CTRL register.
- Inserts a parameterised number of wait states and signals PSLVERR on bad accesses.
- The master writes operands and reads back the result through this block.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_slv_regfile.sv | 59 +++++
 rtl/apb_slave_regs.sv | 94 +++++++++
 tb/tb_apb_slave_regs.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared offsets, STATUS bit positions, FSM encoding and byte-strobe merge for apb_slave_regs
package apb_pkg;
  localparam int APB_DATA_W = 32;
  localparam logic [3:0] OFF_A = 4'h0;
  localparam logic [3:0] OFF_B = 4'h4;
  localparam logic [3:0] OFF_RES = 4'h8;
  localparam logic [3:0] OFF_STAT = 4'hC;
  localparam int ST_CARRY = 0;
  localparam int ST_ERR = 1;
  localparam int ST_ID = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  function automatic logic [APB_DATA_W-1:0] strb_merge(input logic [APB_DATA_W-1:0] old,
                                                       input logic [APB_DATA_W-1:0] din,
                                                       input logic [3:0] strb);
    logic [APB_DATA_W-1:0] m;
    m = old;
    for (int i = 0; i < 4; i++) if (strb[i]) m[8*i +: 8] = din[8*i +: 8];
    return m;
  endfunction
endpackage

// File: rtl/apb_slv_regfile.sv
// apb_slv_regfile: A/B/STATUS storage, A+B adder, read mux and access decode (strobes with APB_SLV_STRB_EN)
module apb_slv_regfile
  import apb_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter logic [3:0] DEV_ID = 4'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  wr,
`ifdef APB_SLV_STRB_EN
  input  logic [3:0]            strb,
  input  logic [3:0]            w_strb,
`endif
  output logic [APB_DATA_W-1:0] rdata,
  output logic                  dec_err,
  input  logic                  we,
  input  logic [1:0]            w_idx,
  input  logic [APB_DATA_W-1:0] w_data,
  input  logic                  set_err
);
  logic [APB_DATA_W-1:0] a, b, stat;
  logic [APB_DATA_W:0] sum;
  logic err, strb_err, clr;
  logic [3:0] ws;
  logic [1:0] idx;
`ifdef APB_SLV_STRB_EN
  assign ws = w_strb;
  assign strb_err = !wr && |strb;
`else
  assign ws = 4'hF;
  assign strb_err = 1'b0;
`endif
  assign idx = addr[3:2];
  assign sum = {1'b0, a} + {1'b0, b};
  assign dec_err = |addr[1:0] || |addr[ADDR_W-1:4] || (wr && idx == OFF_RES[3:2]) || strb_err;
  assign clr = we && w_idx == OFF_STAT[3:2] && w_data[ST_ERR] && ws[0];
  // STATUS image and read mux by word index
  always_comb begin
    stat = '0;
    stat[ST_CARRY] = sum[APB_DATA_W];
    stat[ST_ERR] = err;
    stat[ST_ID +: 4] = DEV_ID;
    rdata = idx == OFF_A[3:2] ? a : idx == OFF_B[3:2] ? b : idx == OFF_RES[3:2] ? sum[APB_DATA_W-1:0] : stat;
  end
  // operand writes and sticky error; a new error beats a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      err <= 1'b0;
    end else begin
      if (we && w_idx == OFF_A[3:2]) a <= strb_merge(a, w_data, ws);
      if (we && w_idx == OFF_B[3:2]) b <= strb_merge(b, w_data, ws);
      err <= set_err || (err && !clr);
    end
  end
endmodule

// File: rtl/apb_slave_regs.sv
// apb_slave_regs: APB3 completer with wait states and PSLVERR; byte strobes with APB_SLV_STRB_EN
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int WAIT_CYCLES = 0,
  parameter logic [3:0] DEV_ID = 4'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [APB_DATA_W-1:0] pwdata,
`ifdef APB_SLV_STRB_EN
  input  logic [3:0]            pstrb,
`endif
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  state_t state, next;
  logic [3:0] cnt;
  logic [1:0] idx_l;
  logic [APB_DATA_W-1:0] wdata_l, rdata_l, rd_mux, src_rd;
  logic wr_l, err_l, dec_err, setup, complete, src_err, src_wr;
`ifdef APB_SLV_STRB_EN
  logic [3:0] strb_l;
`endif
  assign setup = state == IDLE && psel && !penable;
  assign complete = state == RESP && psel && penable;
  assign pready = state == RESP;
  assign pslverr = state == RESP && err_l;
  assign src_err = state == IDLE ? dec_err : err_l;
  assign src_wr = state == IDLE ? pwrite : wr_l;
  assign src_rd = state == IDLE ? rd_mux : rdata_l;
  apb_slv_regfile #(.ADDR_W(ADDR_W), .DEV_ID(DEV_ID)) u_regs (
    .clk(clk),
    .rst(rst),
    .addr(paddr),
    .wr(pwrite),
`ifdef APB_SLV_STRB_EN
    .strb(pstrb),
    .w_strb(strb_l),
`endif
    .rdata(rd_mux),
    .dec_err(dec_err),
    .we(complete && wr_l && !err_l),
    .w_idx(idx_l),
    .w_data(wdata_l),
    .set_err(complete && err_l)
  );
  // next state: losing psel in WAIT/RESP aborts back to IDLE
  always_comb begin
    next = state;
    case (state)
      IDLE: if (setup) next = WAIT_CYCLES == 0 ? RESP : WAIT;
      WAIT: if (!psel) next = IDLE; else if (cnt == 4'd0) next = RESP;
      default: next = IDLE;
    endcase
  end
  // state, setup-phase capture, wait counter and registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      wr_l <= 1'b0;
      err_l <= 1'b0;
      idx_l <= 2'd0;
      wdata_l <= '0;
      rdata_l <= '0;
      prdata <= '0;
`ifdef APB_SLV_STRB_EN
      strb_l <= 4'd0;
`endif
    end else begin
      state <= next;
      if (setup) begin
        cnt <= CNT_INIT;
        wr_l <= pwrite;
        err_l <= dec_err;
        idx_l <= paddr[3:2];
        wdata_l <= pwdata;
        rdata_l <= rd_mux;
`ifdef APB_SLV_STRB_EN
        strb_l <= pstrb;
`endif
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      if (next == RESP) prdata <= src_err ? '0 : src_wr ? prdata : src_rd;
    end
  end
endmodule

// File: tb/tb_apb_slave_regs.sv
// tb_apb_slave_regs: randomized and directed checks of two apb_slave_regs instances against a behavioural model
module tb_apb_slave_regs;
`ifdef APB_SLV_STRB_EN
  localparam bit STRB = 1'b1;
`else
  localparam bit STRB = 1'b0;
`endif
  typedef struct packed {
    logic wr;
    logic [11:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic er;
  } op_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic psel[2], penable[2], pwrite[2], pready[2], pslverr[2];
  logic [11:0] paddr[2];
  logic [31:0] pwdata[2], prdata[2];
  logic [3:0] pstrb[2];
  int wc[2] = '{0, 3};
  int dev[2] = '{1, 10};
  logic [31:0] m_a[2], m_b[2], m_rd[2];
  logic m_err[2];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  apb_slave_regs #(.ADDR_W(12), .WAIT_CYCLES(0), .DEV_ID(4'h1)) dut0 (
    .clk(clk), .rst(rst), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]),
`ifdef APB_SLV_STRB_EN
    .pstrb(pstrb[0]),
`endif
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));
  apb_slave_regs #(.ADDR_W(12), .WAIT_CYCLES(3), .DEV_ID(4'hA)) dut1 (
    .clk(clk), .rst(rst), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]),
`ifdef APB_SLV_STRB_EN
    .pstrb(pstrb[1]),
`endif
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));

  function automatic op_t op(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input logic er);
    return '{wr, a, wd, rd, er};
  endfunction

  task automatic model_reset;
    for (int d = 0; d < 2; d++) begin
      m_a[d] = 0; m_b[d] = 0; m_rd[d] = 0; m_err[d] = 0;
    end
  endtask

  task automatic model(input int d, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                       input logic [3:0] s, output logic [31:0] erd, output logic eer);
    logic [63:0] sum;
    logic [31:0] mask;
    int w, carry;
    sum = 64'(m_a[d]) + 64'(m_b[d]);
    carry = sum > 64'hFFFF_FFFF ? 1 : 0;
    w = int'(a) / 4 % 4;
    eer = (a % 4 != 0) || (a >= 16) || (wr && w == 2) || (STRB && !wr && s != 0);
    mask = 0;
    for (int i = 0; i < 4; i++) if (s[i]) mask = mask | (32'hFF << (8 * i));
    if (eer) begin
      erd = 0;
      m_err[d] = 1'b1;
    end else if (wr) begin
      erd = m_rd[d];
      if (w == 0) m_a[d] = (m_a[d] & ~mask) | (wd & mask);
      if (w == 1) m_b[d] = (m_b[d] & ~mask) | (wd & mask);
      if (w == 3 && wd[1] && s[0]) m_err[d] = 1'b0;
    end else begin
      erd = w == 0 ? m_a[d] : w == 1 ? m_b[d] : w == 2 ? sum[31:0] :
            32'(dev[d] * 16 + (m_err[d] ? 2 : 0) + carry);
    end
    m_rd[d] = erd;
  endtask

  task automatic xfer(input int d, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                      input logic [3:0] s, output logic [31:0] rd, output logic er, output int lat);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd; pstrb[d] = s;
    @(posedge clk); #1 penable[d] = 1'b1;
    lat = 2;
    while (!pready[d] && lat < 40) begin
      @(posedge clk); #1 lat++;
    end
    rd = prdata[d];
    er = pslverr[d];
    @(posedge clk); #1 psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      n_chk++; if (pready[d] !== 1'b0) begin n_fail++; $display("FAIL reset_pready d%0d got %b want 0", d, pready[d]); end
      n_chk++; if (pslverr[d] !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr d%0d got %b want 0", d, pslverr[d]); end
      n_chk++; if (prdata[d] !== 32'h0) begin n_fail++; $display("FAIL reset_prdata d%0d got %h want 0", d, prdata[d]); end
    end
  endtask

  task automatic test_zero_wait;
    op_t ops[3];
    logic [31:0] erd, rd;
    logic eer, er;
    int lat;
    ops[0] = op(1, 12'h000, 32'd1, 32'd0, 0);
    ops[1] = op(1, 12'h004, 32'd2, 32'd0, 0);
    ops[2] = op(0, 12'h008, 32'd0, 32'd3, 0);
    foreach (ops[i]) begin
      model(0, ops[i].wr, ops[i].a, ops[i].wd, ops[i].wr ? 4'hF : 4'h0, erd, eer);
      xfer(0, ops[i].wr, ops[i].a, ops[i].wd, ops[i].wr ? 4'hF : 4'h0, rd, er, lat);
      n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL zw_latency op%0d got %0d want 2", i, lat); end
      n_chk++; if (er !== ops[i].er) begin n_fail++; $display("FAIL zw_pslverr op%0d got %b want %b", i, er, ops[i].er); end
      if (!ops[i].wr) begin
        n_chk++; if (rd !== ops[i].rd) begin n_fail++; $display("FAIL zw_prdata op%0d got %h want %h", i, rd, ops[i].rd); end
      end
    end
  endtask

  task automatic test_wait_states;
    op_t ops[2];
    logic [31:0] erd, rd;
    logic eer, er;
    int lat;
    ops[0] = op(1, 12'h000, 32'd5, 32'd0, 0);
    ops[1] = op(0, 12'h000, 32'd0, 32'd5, 0);
    foreach (ops[i]) begin
      model(1, ops[i].wr, ops[i].a, ops[i].wd, ops[i].wr ? 4'hF : 4'h0, erd, eer);
      xfer(1, ops[i].wr, ops[i].a, ops[i].wd, ops[i].wr ? 4'hF : 4'h0, rd, er, lat);
      n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL ws_latency op%0d got %0d want 5", i, lat); end
      n_chk++; if (er !== ops[i].er) begin n_fail++; $display("FAIL ws_pslverr op%0d got %b want %b", i, er, ops[i].er); end
      if (!ops[i].wr) begin
        n_chk++; if (rd !== ops[i].rd) begin n_fail++; $display("FAIL ws_prdata op%0d got %h want %h", i, rd, ops[i].rd); end
      end
    end
  endtask

  task automatic test_carry;
    op_t ops[4];
    logic [31:0] erd, rd;
    logic eer, er;
    int lat;
    ops[0] = op(1, 12'h000, 32'hFFFF_FFFF, 32'd0, 0);
    ops[1] = op(1, 12'h004, 32'd2, 32'd0, 0);
    ops[2] = op(0, 12'h008, 32'd0, 32'd1, 0);
    ops[3] = op(0, 12'h00C, 32'd0, 32'h11, 0);
    foreach (ops[i]) begin
      model(0, ops[i].wr, ops[i].a, ops[i].wd, ops[i].wr ? 4'hF : 4'h0, erd, eer);
      xfer(0, ops[i].wr, ops[i].a, ops[i].wd, ops[i].wr ? 4'hF : 4'h0, rd, er, lat);
      n_chk++; if (er !== ops[i].er) begin n_fail++; $display("FAIL carry_pslverr op%0d got %b want %b", i, er, ops[i].er); end
      if (!ops[i].wr) begin
        n_chk++; if (rd !== ops[i].rd) begin n_fail++; $display("FAIL carry_prdata op%0d got %h want %h", i, rd, ops[i].rd); end
      end
    end
  endtask

  task automatic test_errors;
    op_t ops[8];
    logic [31:0] erd, rd;
    logic eer, er;
    int lat;
    ops[0] = op(1, 12'h008, 32'h55, 32'd0, 1);
    ops[1] = op(0, 12'h010, 32'd0, 32'd0, 1);
    ops[2] = op(0, 12'h002, 32'd0, 32'd0, 1);
    ops[3] = op(0, 12'h000, 32'd0, 32'hFFFF_FFFF, 0);
    ops[4] = op(0, 12'h004, 32'd0, 32'd2, 0);
    ops[5] = op(0, 12'h00C, 32'd0, 32'h13, 0);
    ops[6] = op(1, 12'h00C, 32'h2, 32'd0, 0);
    ops[7] = op(0, 12'h00C, 32'd0, 32'h11, 0);
    foreach (ops[i]) begin
      model(0, ops[i].wr, ops[i].a, ops[i].wd, ops[i].wr ? 4'hF : 4'h0, erd, eer);
      xfer(0, ops[i].wr, ops[i].a, ops[i].wd, ops[i].wr ? 4'hF : 4'h0, rd, er, lat);
      n_chk++; if (er !== ops[i].er) begin n_fail++; $display("FAIL err_pslverr op%0d got %b want %b", i, er, ops[i].er); end
      if (!ops[i].wr || ops[i].er) begin
        n_chk++; if (rd !== ops[i].rd) begin n_fail++; $display("FAIL err_prdata op%0d got %h want %h", i, rd, ops[i].rd); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] erd, rd;
    logic eer, er;
    int lat;
    for (int i = 0; i < 6; i++) begin
      logic wr;
      logic [11:0] a;
      logic [31:0] wd;
      wr = i < 2;
      a = 12'((i % 2) * 4);
      wd = $urandom;
      model(0, wr, a, wd, wr ? 4'hF : 4'h0, erd, eer);
      xfer(0, wr, a, wd, wr ? 4'hF : 4'h0, rd, er, lat);
      n_chk++; if (rd !== erd || er !== eer || lat !== 2) begin
        n_fail++; $display("FAIL b2b op%0d got rd=%h err=%b lat=%0d want rd=%h err=%b lat=2", i, rd, er, lat, erd, eer);
      end
    end
  endtask

  task automatic test_idle_penable;
    logic [31:0] erd, rd;
    logic eer, er;
    int lat;
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 12'h000; pwdata[0] = 32'hDEAD_0000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_chk++; if (pready[0] !== 1'b0) begin n_fail++; $display("FAIL idle_penable cyc%0d pready got %b want 0", i, pready[0]); end
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(posedge clk); #1;
    model(0, 0, 12'h000, 0, 4'h0, erd, eer);
    xfer(0, 0, 12'h000, 0, 4'h0, rd, er, lat);
    n_chk++; if (rd !== erd || er !== eer) begin
      n_fail++; $display("FAIL idle_penable_nowrite got rd=%h err=%b want rd=%h err=%b", rd, er, erd, eer);
    end
  endtask

  task automatic test_strb;
`ifdef APB_SLV_STRB_EN
    logic [31:0] erd, rd;
    logic eer, er;
    int lat;
    model(0, 1, 12'h000, 32'h1122_3344, 4'hF, erd, eer); xfer(0, 1, 12'h000, 32'h1122_3344, 4'hF, rd, er, lat);
    model(0, 1, 12'h000, 32'hAABB_CCDD, 4'h5, erd, eer); xfer(0, 1, 12'h000, 32'hAABB_CCDD, 4'h5, rd, er, lat);
    model(0, 0, 12'h000, 0, 4'h0, erd, eer); xfer(0, 0, 12'h000, 0, 4'h0, rd, er, lat);
    n_chk++; if (rd !== 32'h11BB_33DD || er !== 1'b0) begin n_fail++; $display("FAIL strb_merge got rd=%h err=%b want 11bb33dd err=0", rd, er); end
    model(0, 0, 12'h000, 0, 4'h1, erd, eer); xfer(0, 0, 12'h000, 0, 4'h1, rd, er, lat);
    n_chk++; if (rd !== 32'h0 || er !== 1'b1) begin n_fail++; $display("FAIL strb_read_err got rd=%h err=%b want 0 err=1", rd, er); end
    model(0, 1, 12'h000, 32'h0, 4'h0, erd, eer); xfer(0, 1, 12'h000, 32'h0, 4'h0, rd, er, lat);
    n_chk++; if (er !== 1'b0) begin n_fail++; $display("FAIL strb_zero_write err got %b want 0", er); end
    model(0, 1, 12'h00C, 32'h2, 4'hE, erd, eer); xfer(0, 1, 12'h00C, 32'h2, 4'hE, rd, er, lat);
    model(0, 0, 12'h00C, 0, 4'h0, erd, eer); xfer(0, 0, 12'h00C, 0, 4'h0, rd, er, lat);
    n_chk++; if (rd !== erd || rd[1] !== 1'b1) begin n_fail++; $display("FAIL strb_clear_needs_b0 got %h want %h", rd, erd); end
    model(0, 0, 12'h000, 0, 4'h0, erd, eer); xfer(0, 0, 12'h000, 0, 4'h0, rd, er, lat);
    n_chk++; if (rd !== 32'h11BB_33DD) begin n_fail++; $display("FAIL strb_zero_nochange got %h want 11bb33dd", rd); end
`endif
  endtask

  task automatic test_random;
    logic [31:0] erd, rd, wd;
    logic eer, er, wr;
    logic [11:0] a;
    logic [3:0] s;
    int d, lat, r;
    for (int i = 0; i < 150; i++) begin
      d = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      a = r < 8 ? 12'((r % 4) * 4) : r == 8 ? 12'($urandom_range(16, 4095)) :
          12'($urandom_range(0, 3) * 4 + $urandom_range(1, 3));
      wd = $urandom;
      s = STRB ? 4'($urandom_range(0, 15)) : (wr ? 4'hF : 4'h0);
      if (STRB && !wr && $urandom_range(0, 1) == 0) s = 4'h0;
      model(d, wr, a, wd, s, erd, eer);
      xfer(d, wr, a, wd, s, rd, er, lat);
      n_chk++; if (rd !== erd) begin n_fail++; $display("FAIL rand_prdata #%0d d%0d a=%h got %h want %h", i, d, a, rd, erd); end
      n_chk++; if (er !== eer) begin n_fail++; $display("FAIL rand_pslverr #%0d d%0d a=%h got %b want %b", i, d, a, er, eer); end
      n_chk++; if (lat !== 2 + wc[d]) begin n_fail++; $display("FAIL rand_latency #%0d d%0d got %0d want %0d", i, d, lat, 2 + wc[d]); end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_abort;
    logic [31:0] erd, rd;
    logic eer, er;
    int lat, k;
    model(1, 1, 12'h000, 32'h99, 4'hF, erd, eer); xfer(1, 1, 12'h000, 32'h99, 4'hF, rd, er, lat);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 12'h000; pwdata[1] = 32'h77; pstrb[1] = 4'hF;
    @(posedge clk); #1 penable[1] = 1'b1;
    n_chk++; if (pready[1] !== 1'b0) begin n_fail++; $display("FAIL abort_wait_pready got %b want 0", pready[1]); end
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (pready[1] !== 1'b0) begin n_fail++; $display("FAIL abort_idle_pready got %b want 0", pready[1]); end
    model(1, 0, 12'h00C, 0, 4'h0, erd, eer); xfer(1, 0, 12'h00C, 0, 4'h0, rd, er, lat);
    n_chk++; if (rd !== erd || er !== eer) begin n_fail++; $display("FAIL abort_no_err got %h want %h", rd, erd); end
    model(1, 0, 12'h000, 0, 4'h0, erd, eer); xfer(1, 0, 12'h000, 0, 4'h0, rd, er, lat);
    n_chk++; if (rd !== 32'h99) begin n_fail++; $display("FAIL abort_no_write got %h want 00000099", rd); end
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 12'h000; pwdata[1] = 32'h77;
    @(posedge clk); #1 penable[1] = 1'b1;
    k = 0;
    while (!pready[1] && k < 40) begin @(posedge clk); #1 k++; end
    n_chk++; if (pready[1] !== 1'b1) begin n_fail++; $display("FAIL abort_reach_resp pready got %b want 1", pready[1]); end
    rst = 1'b1;
    #1;
    n_chk++; if (pready[1] !== 1'b0 || pslverr[1] !== 1'b0 || prdata[1] !== 32'h0) begin
      n_fail++; $display("FAIL abort_rst_outputs got pready=%b pslverr=%b prdata=%h want 0 0 0", pready[1], pslverr[1], prdata[1]);
    end
    @(posedge clk); #1 psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    for (int w = 0; w < 2; w++) begin
      model(1, 0, 12'(w * 4), 0, 4'h0, erd, eer); xfer(1, 0, 12'(w * 4), 0, 4'h0, rd, er, lat);
      n_chk++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL abort_rst_regs w%0d got %h err=%b want 0 err=0", w, rd, er); end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_zero_wait();
    test_wait_states();
    test_carry();
    test_errors();
    test_back_to_back();
    test_idle_penable();
    test_strb();
    test_random();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
